// File: rtl/count_run_ctrl.sv
// Run/pause/clear controller plus multiplexed display scan scheduler for a
// 3-digit BCD counter datapath. Every output comes straight from a register.
module count_run_ctrl #(
    parameter int TICK_DIV = 10000000,
    parameter int SCAN_DIV = 50000,
    parameter int NUM_DIG  = 3,
    parameter int GUARD    = 16
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       BTN_RUN,
    input  logic       BTN_CLR,
    input  logic       MODE_WRAP,
    input  logic       CNT_MAX,
    output logic       CNT_EN,
    output logic       CNT_CLR,
    output logic [2:0] SCAN_IDX,
    output logic [7:0] SEG_SEL,
    output logic       BLANK,
    output logic [1:0] STATE
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [SW-1:0] GUARD_END  = SW'(GUARD);
    localparam logic [2:0]    IDX_LAST   = 3'(NUM_DIG - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state_q;
    logic [PW-1:0] presc_q;
    logic          cnt_en_q;
    logic          cnt_clr_q;
    logic [2:0]    run_sync_q;
    logic [2:0]    clr_sync_q;
    logic          run_press_q;
    logic          clr_press_q;
    logic          tick;

    logic [SW-1:0] scan_cnt_q, scan_cnt_d;
    logic [2:0]    scan_idx_q, scan_idx_d;
    logic          blank_q, blank_d;
    logic [7:0]    seg_sel_q, seg_sel_d;

    // [0],[1] form the 2-FF synchroniser; [2] is the delayed copy for edge detect.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            run_sync_q  <= '0;
            clr_sync_q  <= '0;
            run_press_q <= 1'b0;
            clr_press_q <= 1'b0;
        end else begin
            run_sync_q  <= {run_sync_q[1:0], BTN_RUN};
            clr_sync_q  <= {clr_sync_q[1:0], BTN_CLR};
            run_press_q <= run_sync_q[1] & ~run_sync_q[2];
            clr_press_q <= clr_sync_q[1] & ~clr_sync_q[2];
        end
    end

    assign tick = (presc_q == PRESC_LAST);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= IDLE;
            presc_q   <= '0;
            cnt_en_q  <= 1'b0;
            cnt_clr_q <= 1'b0;
        end else begin
            cnt_en_q  <= 1'b0;
            cnt_clr_q <= 1'b0;
            if (clr_press_q) begin
                state_q   <= IDLE;
                presc_q   <= '0;
                cnt_clr_q <= 1'b1;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (run_press_q) begin
                            state_q <= RUN;
                            presc_q <= '0;
                        end
                    end
                    RUN: begin
                        if (tick) begin
                            presc_q <= '0;
                            if (CNT_MAX && !MODE_WRAP) begin
                                state_q <= DONE;
                            end else begin
                                // A pause press on a tick still lets this step through.
                                cnt_en_q <= 1'b1;
                                if (run_press_q) state_q <= PAUSE;
                            end
                        end else if (run_press_q) begin
                            state_q <= PAUSE;
                        end else begin
                            presc_q <= presc_q + PW'(1);
                        end
                    end
                    PAUSE: begin
                        if (run_press_q) state_q <= RUN;
                    end
                    DONE: begin
                    end
                endcase
            end
        end
    end

    // Blank and select are derived from the next scan position so they stay
    // aligned with the counter; the index only moves at a wrap, inside the guard.
    always_comb begin
        scan_cnt_d = (scan_cnt_q == SCAN_LAST) ? '0 : scan_cnt_q + SW'(1);
        scan_idx_d = scan_idx_q;
        if (scan_cnt_q == SCAN_LAST) begin
            scan_idx_d = (scan_idx_q == IDX_LAST) ? 3'd0 : scan_idx_q + 3'd1;
        end
        blank_d   = (scan_cnt_d < GUARD_END);
        seg_sel_d = 8'hFF;
        if (!blank_d) seg_sel_d[scan_idx_d] = 1'b0;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            scan_cnt_q <= '0;
            scan_idx_q <= 3'd0;
            blank_q    <= 1'b1;
            seg_sel_q  <= 8'hFF;
        end else begin
            scan_cnt_q <= scan_cnt_d;
            scan_idx_q <= scan_idx_d;
            blank_q    <= blank_d;
            seg_sel_q  <= seg_sel_d;
        end
    end

    assign CNT_EN   = cnt_en_q;
    assign CNT_CLR  = cnt_clr_q;
    assign SCAN_IDX = scan_idx_q;
    assign SEG_SEL  = seg_sel_q;
    assign BLANK    = blank_q;
    assign STATE    = state_q;

endmodule

// File: tb/tb_count_run_ctrl.sv
// Bench for count_run_ctrl: directed button sequences, with CNT_EN/CNT_CLR
// pulses matched against a queue of expected (cycle, kind) events.
module tb_count_run_ctrl;
    localparam int TICK_DIV = 4;
    localparam int SCAN_DIV = 8;
    localparam int NUM_DIG  = 3;
    localparam int GUARD    = 2;

    logic       CLK;
    logic       RESET;
    logic       BTN_RUN;
    logic       BTN_CLR;
    logic       MODE_WRAP;
    logic       CNT_MAX;
    logic       CNT_EN;
    logic       CNT_CLR;
    logic [2:0] SCAN_IDX;
    logic [7:0] SEG_SEL;
    logic       BLANK;
    logic [1:0] STATE;

    count_run_ctrl #(
        .TICK_DIV(TICK_DIV),
        .SCAN_DIV(SCAN_DIV),
        .NUM_DIG (NUM_DIG),
        .GUARD   (GUARD)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .BTN_RUN  (BTN_RUN),
        .BTN_CLR  (BTN_CLR),
        .MODE_WRAP(MODE_WRAP),
        .CNT_MAX  (CNT_MAX),
        .CNT_EN   (CNT_EN),
        .CNT_CLR  (CNT_CLR),
        .SCAN_IDX (SCAN_IDX),
        .SEG_SEL  (SEG_SEL),
        .BLANK    (BLANK),
        .STATE    (STATE)
    );

    typedef struct {
        int cyc;
        int clr;
    } ev_t;

    ev_t sb_q[$];
    int  cyc;
    int  errors = 0;
    int  checks = 0;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Number of active edges since reset was released.
    always @(posedge CLK or posedge RESET) begin
        if (RESET) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_ev(input int c, input int clr);
        ev_t e;
        e.cyc = c;
        e.clr = clr;
        sb_q.push_back(e);
    endtask

    task automatic at(input int n);
        int guard = 0;
        while (cyc < n && guard < 2000) begin
            @(negedge CLK);
            guard++;
        end
        if (cyc != n) begin
            checks++;
            errors++;
            $display("FAIL wait_cycle: at cycle %0d, expected cycle %0d", cyc, n);
        end
    endtask

    // Monitor: scan outputs every cycle from a free-running model, and every
    // CNT_EN/CNT_CLR pulse against the head of the expected-event queue.
    always @(negedge CLK) begin
        if (!RESET) begin
            int   slot;
            int   idx;
            int   blk;
            logic [7:0] seg;
            slot = cyc % SCAN_DIV;
            idx  = (cyc / SCAN_DIV) % NUM_DIG;
            blk  = (slot < GUARD) ? 1 : 0;
            seg  = 8'hFF;
            if (blk == 0) seg[idx] = 1'b0;
            chk("scan_idx_sel_blank", {SCAN_IDX, SEG_SEL, BLANK}, {idx[2:0], seg, blk[0]});
            if (CNT_EN || CNT_CLR) begin
                chk("en_clr_exclusive", int'(CNT_EN & CNT_CLR), 0);
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse: CNT_EN=%0d CNT_CLR=%0d, expected none (cycle %0d)",
                             CNT_EN, CNT_CLR, cyc);
                end else begin
                    ev_t e;
                    e = sb_q.pop_front();
                    chk("pulse_cycle", cyc, e.cyc);
                    chk("pulse_kind_clr", int'(CNT_CLR), e.clr);
                end
            end
        end
    end

    initial begin
        RESET     = 1'b1;
        BTN_RUN   = 1'b0;
        BTN_CLR   = 1'b0;
        MODE_WRAP = 1'b1;
        CNT_MAX   = 1'b0;
        #7;
        chk("rst_state", STATE, 0);
        chk("rst_cnt_en", CNT_EN, 0);
        chk("rst_cnt_clr", CNT_CLR, 0);
        chk("rst_seg_sel", SEG_SEL, 8'hFF);
        chk("rst_blank", BLANK, 1);
        chk("rst_scan_idx", SCAN_IDX, 0);
        @(negedge CLK);
        RESET = 1'b0;

        // Idle scanning, then a held run press.
        at(20);
        chk("idle_state", STATE, 0);
        BTN_RUN = 1'b1;
        push_ev(28, 0);
        push_ev(32, 0);
        push_ev(36, 0);
        at(23); chk("run_latency_pre", STATE, 0);
        at(24); chk("run_entry", STATE, 1);
        at(30); chk("run_held_single_press", STATE, 1);
        BTN_RUN = 1'b0;

        // Pause with the prescaler at 2, then resume two cycles short of a tick.
        at(35); BTN_RUN = 1'b1;
        at(37); BTN_RUN = 1'b0;
        at(38); chk("pause_pre", STATE, 1);
        at(39); chk("pause_entry", STATE, 2);
        at(49); BTN_RUN = 1'b1;
        push_ev(55, 0);
        push_ev(59, 0);
        at(51); BTN_RUN = 1'b0;
        at(52); chk("paused_hold", STATE, 2);
        at(53); chk("resume_entry", STATE, 1);

        // Count at 999: wrap mode steps, stop mode goes to DONE.
        at(56); CNT_MAX = 1'b1; MODE_WRAP = 1'b1;
        at(60); chk("wrap_stays_run", STATE, 1);
        MODE_WRAP = 1'b0;
        at(62); chk("stop_pre", STATE, 1);
        at(63); chk("done_entry", STATE, 3);
        at(64); BTN_RUN = 1'b1;
        at(66); BTN_RUN = 1'b0; MODE_WRAP = 1'b1;
        at(70); chk("done_ignores_run_and_mode", STATE, 3);
        BTN_CLR = 1'b1;
        push_ev(74, 1);
        at(72); BTN_CLR = 1'b0;
        at(73); chk("clear_pre", STATE, 3);
        at(74); chk("clear_from_done", STATE, 0);
        CNT_MAX = 1'b0;

        // Run, pause, then simultaneous run+clear: clear wins.
        at(76); BTN_RUN = 1'b1;
        push_ev(84, 0);
        at(78); BTN_RUN = 1'b0;
        at(80); chk("rerun_entry", STATE, 1);
        at(82); BTN_RUN = 1'b1;
        at(84); BTN_RUN = 1'b0;
        at(86); chk("pause2_entry", STATE, 2);
        at(90); BTN_RUN = 1'b1; BTN_CLR = 1'b1;
        push_ev(94, 1);
        at(92); BTN_RUN = 1'b0; BTN_CLR = 1'b0;
        at(94); chk("clr_beats_run", STATE, 0);
        at(96); chk("clr_beats_run_hold", STATE, 0);

        // Asynchronous reset in the middle of a CNT_EN pulse, between edges.
        at(100); BTN_RUN = 1'b1;
        push_ev(108, 0);
        push_ev(112, 0);
        push_ev(116, 0);
        at(102); BTN_RUN = 1'b0;
        at(104); chk("run3_entry", STATE, 1);
        at(116);
        #1 RESET = 1'b1;
        #1;
        chk("async_rst_state", STATE, 0);
        chk("async_rst_cnt_en", CNT_EN, 0);
        chk("async_rst_seg_sel", SEG_SEL, 8'hFF);
        chk("async_rst_blank", BLANK, 1);
        chk("async_rst_scan_idx", SCAN_IDX, 0);
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        at(20);
        chk("post_reset_idle", STATE, 0);
        chk("scoreboard_drained", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
